// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } kp_state_t;

   localparam int KP_ROWS = 4;
   localparam int KP_COLS = 4;
   localparam logic [KP_ROWS-1:0] KP_RELEASED = 4'b1111;

   // Rows are active-low; the lowest-indexed low row wins when several are pressed.
   function automatic logic [1:0] low_row_idx(input logic [KP_ROWS-1:0] r);
      logic [1:0] idx;
      idx = '0;
      for (int i = KP_ROWS - 1; i >= 0; i--) begin
         if (!r[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scan_row_sync.sv
// Two-flop synchronizer for active-low inputs; resets to all-ones (nothing pressed).
module row_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '1;
         dout <= '1;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner: drives one column low at a time, debounces
// press and release, and reports each accepted key once.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 500000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [KP_ROWS-1:0] row,
   output logic [KP_COLS-1:0] col,
   output logic               key_valid,
   output logic [3:0]         key_code,
   output logic               key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT);
   localparam int IW = $clog2(KP_COLS);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);

   kp_state_t          state, state_n;
   logic [DW-1:0]      dwell, dwell_n;
   logic [CW-1:0]      deb, deb_n;
   logic [IW-1:0]      col_idx, col_idx_n;
   logic [KP_ROWS-1:0] row_s, row_lat, row_lat_n;
   logic               key_valid_n, key_held_n;
   logic [3:0]         key_code_n;

   row_sync #(.WIDTH(KP_ROWS)) u_row_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (row),
      .dout (row_s)
   );

   assign col = ~(KP_COLS'(1) << col_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_SCAN;
         dwell     <= '0;
         deb       <= '0;
         col_idx   <= '0;
         row_lat   <= KP_RELEASED;
         key_valid <= 1'b0;
         key_code  <= '0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_n;
         dwell     <= dwell_n;
         deb       <= deb_n;
         col_idx   <= col_idx_n;
         row_lat   <= row_lat_n;
         key_valid <= key_valid_n;
         key_code  <= key_code_n;
         key_held  <= key_held_n;
      end
   end

   // The column stays frozen outside SCAN so the latched row pattern keeps meaning.
   always_comb begin
      state_n     = state;
      dwell_n     = dwell;
      deb_n       = deb;
      col_idx_n   = col_idx;
      row_lat_n   = row_lat;
      key_valid_n = 1'b0;
      key_code_n  = key_code;
      key_held_n  = key_held;
      case (state)
         ST_SCAN: begin
            if (dwell == DWELL_LAST) begin
               dwell_n = '0;
               if (row_s != KP_RELEASED) begin
                  row_lat_n = row_s;
                  deb_n     = '0;
                  state_n   = ST_DEBOUNCE;
               end else begin
                  col_idx_n = col_idx + IW'(1);
               end
            end else begin
               dwell_n = dwell + DW'(1);
            end
         end
         ST_DEBOUNCE: begin
            if (row_s == row_lat) begin
               if (deb == DEB_LAST) begin
                  key_valid_n = 1'b1;
                  key_code_n  = {low_row_idx(row_lat), col_idx};
                  key_held_n  = 1'b1;
                  state_n     = ST_HELD;
               end else begin
                  deb_n = deb + CW'(1);
               end
            end else begin
               col_idx_n = col_idx + IW'(1);
               dwell_n   = '0;
               state_n   = ST_SCAN;
            end
         end
         ST_HELD: begin
            if (row_s == KP_RELEASED) begin
               deb_n   = '0;
               state_n = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (row_s != KP_RELEASED) begin
               state_n = ST_HELD;
            end else if (deb == DEB_LAST) begin
               key_held_n = 1'b0;
               col_idx_n  = col_idx + IW'(1);
               dwell_n    = '0;
               state_n    = ST_SCAN;
            end else begin
               deb_n = deb + CW'(1);
            end
         end
         default: state_n = ST_SCAN;
      endcase
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=8; accepted
// presses are checked against a queue of expected key codes.
module tb_keypad_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row = 4'b1111;
   logic [3:0] col;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;

   int         n_asserts = 0;
   int         n_fail = 0;
   logic [3:0] expq[$];
   logic       prev_valid = 1'b0;
   logic       rst_prev = 1'b1;
   logic [3:0] last_code = 4'd0;

   keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      n_asserts++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] row_val);
      row = row_val;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves the bench in the first cycle that the requested column is driven.
   task automatic waitCol(input logic [3:0] target);
      int   n;
      logic found;
      n = 0;
      while (col === target && n < 40) begin tick(1); n++; end
      while (col !== target && n < 40) begin tick(1); n++; end
      found = (col === target);
      checkOutput("wait_col", {3'b0, found}, 4'd1);
   endtask

   task automatic doPress(input logic [3:0] col_target, input logic [3:0] row_val, input logic [3:0] exp_code);
      waitCol(col_target);
      applyStimulus(row_val);
      expq.push_back(exp_code);
      tick(11);
      checkOutput("held_before_accept", {3'b0, key_held}, 4'd0);
      tick(1);
      checkOutput("held_rise", {3'b0, key_held}, 4'd1);
      checkOutput("code_on_accept", key_code, exp_code);
   endtask

   task automatic doRelease(input logic [3:0] next_col);
      applyStimulus(4'b1111);
      tick(10);
      checkOutput("held_before_release", {3'b0, key_held}, 4'd1);
      tick(1);
      checkOutput("held_fall", {3'b0, key_held}, 4'd0);
      checkOutput("col_after_release", col, next_col);
   endtask

   // Scoreboard side: every key_valid pulse consumes one expected code.
   always @(negedge clk) begin
      logic [3:0] exp_c;
      if (key_valid === 1'b1) begin
         checkOutput("valid_single_cycle", {3'b0, prev_valid}, 4'd0);
         if (expq.size() > 0) begin
            exp_c = expq.pop_front();
            checkOutput("sb_code", key_code, exp_c);
         end else begin
            checkOutput("sb_unexpected_valid", {3'b0, key_valid}, 4'd0);
         end
      end else if (!rst_prev) begin
         checkOutput("code_stable", key_code, last_code);
      end
      prev_valid = key_valid;
      last_code  = key_code;
      rst_prev   = rst;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      logic [3:0] exp_col;
      logic [3:0] one;
      int         qsize;
      one = 4'b0001;

      $display("[TB] reset and idle rotation");
      rst = 1'b1;
      applyStimulus(4'b1111);
      tick(2);
      rst = 1'b0;
      for (int c = 0; c <= 16; c++) begin
         exp_col = ~(one << ((c / 4) % 4));
         checkOutput("idle_col", col, exp_col);
         checkOutput("idle_valid", {3'b0, key_valid}, 4'd0);
         checkOutput("idle_held", {3'b0, key_held}, 4'd0);
         checkOutput("idle_code", key_code, 4'd0);
         tick(1);
      end

      $display("[TB] clean press");
      doPress(4'b1011, 4'b1101, 4'd6);
      tick(18);
      checkOutput("held_during_press", {3'b0, key_held}, 4'd1);
      checkOutput("col_frozen_held", col, 4'b1011);
      doRelease(4'b0111);

      $display("[TB] press bounce");
      waitCol(4'b1101);
      applyStimulus(4'b1110);
      tick(5);
      applyStimulus(4'b1111);
      tick(2);
      checkOutput("bounce_col_frozen", col, 4'b1101);
      checkOutput("bounce_held_a", {3'b0, key_held}, 4'd0);
      tick(1);
      checkOutput("bounce_col_advance", col, 4'b1011);
      checkOutput("bounce_held_b", {3'b0, key_held}, 4'd0);

      $display("[TB] multi-row priority");
      doPress(4'b1101, 4'b1010, 4'd1);
      doRelease(4'b1011);

      $display("[TB] release bounce");
      doPress(4'b1110, 4'b0111, 4'd12);
      applyStimulus(4'b1111);
      tick(3);
      checkOutput("rel_bounce_held_a", {3'b0, key_held}, 4'd1);
      applyStimulus(4'b0111);
      tick(2);
      checkOutput("rel_bounce_held_b", {3'b0, key_held}, 4'd1);
      doRelease(4'b1101);

      $display("[TB] reset while held");
      doPress(4'b0111, 4'b1011, 4'd11);
      rst = 1'b1;
      applyStimulus(4'b1111);
      tick(1);
      rst = 1'b0;
      checkOutput("rst_held", {3'b0, key_held}, 4'd0);
      checkOutput("rst_code", key_code, 4'd0);
      checkOutput("rst_col", col, 4'b1110);
      checkOutput("rst_valid", {3'b0, key_valid}, 4'd0);
      tick(3);
      checkOutput("rst_dwell_hold", col, 4'b1110);
      tick(1);
      checkOutput("rst_dwell_advance", col, 4'b1101);

      tick(2);
      qsize = expq.size();
      checkOutput("sb_all_consumed", 4'(qsize), 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
